// File: rtl/grf_pkg.sv
// Shared constants for the general register file slice.
package grf_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NREG       = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/grf_if.sv
// Register-file bus: read/write ports plus the registered commit debug view.
interface grf_if
    import grf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              we;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd;
    logic [31:0]       pc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_a3;
    logic [DATA_W-1:0] dbg_wd;

    modport master (
        output we, a1, a2, a3, wd, pc,
        input  rd1, rd2, dbg_we, dbg_a3, dbg_wd
    );

    modport slave (
        input  we, a1, a2, a3, wd, pc,
        output rd1, rd2, dbg_we, dbg_a3, dbg_wd
    );
endinterface

// File: rtl/grf_read_port.sv
// One combinational read port: $0 forced to zero, optional same-cycle write bypass.
module grf_read_port
    import grf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter bit          BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] an,
    input  logic [DATA_W-1:0] regs [1 << ADDR_W],
    input  logic              commit,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);
    always_comb begin
        rd = '0;
        if (an != '0) begin
            // commit already excludes reset, so bypass is naturally off during reset
            if (BYPASS && commit && (a3 == an)) begin
                rd = wd;
            end else begin
                rd = regs[an];
            end
        end
    end
endmodule

// File: rtl/grf.sv
// General register file: $0 hardwired to zero, two combinational reads, one synchronous write.
module grf
    import grf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter bit          BYPASS = 1'b1
) (
    input logic  clk,
    input logic  reset,
    grf_if.slave bus
);
    localparam int unsigned NR = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NR];
    logic              commit;

    always_comb begin
        commit = bus.we && !reset && (bus.a3 != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NR; i++) begin
                regs[i] <= '0;
            end
            bus.dbg_we <= 1'b0;
            bus.dbg_a3 <= '0;
            bus.dbg_wd <= '0;
        end else begin
            bus.dbg_we <= commit;
            if (commit) begin
                regs[bus.a3] <= bus.wd;
                bus.dbg_a3   <= bus.a3;
                bus.dbg_wd   <= bus.wd;
            end
        end
    end

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rp1 (
        .an     (bus.a1),
        .regs   (regs),
        .commit (commit),
        .a3     (bus.a3),
        .wd     (bus.wd),
        .rd     (bus.rd1)
    );

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rp2 (
        .an     (bus.a2),
        .regs   (regs),
        .commit (commit),
        .a3     (bus.a3),
        .wd     (bus.wd),
        .rd     (bus.rd2)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (commit) begin
            $display("@%08h: $%2d <= %08h", bus.pc, bus.a3, bus.wd);
        end
    end
`endif
endmodule

// File: tb/tb_grf.sv
// Directed bench for grf: one instance with bypass, one without, fed identical stimulus.
module tb_grf;
    import grf_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    grf_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    grf_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

    grf #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    grf #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nob (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        bus1.we = we; bus1.a1 = a1; bus1.a2 = a2; bus1.a3 = a3; bus1.wd = wd; bus1.pc = pc;
        bus0.we = we; bus0.a1 = a1; bus0.a2 = a2; bus0.a3 = a3; bus0.wd = wd; bus0.pc = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] e1;
        logic [31:0] e2;

        reset = 1'b1;
        drive(1'b0, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0);
        step();
        step();
        chk("rst_rd1", bus1.rd1, 32'h0);
        chk("rst_dbg_we", {31'b0, bus1.dbg_we}, 32'h0);
        chk("rst_dbg_a3", {27'b0, bus1.dbg_a3}, 32'h0);
        chk("rst_dbg_wd", bus1.dbg_wd, 32'h0);

        // basic write to $5
        reset = 1'b0;
        drive(1'b1, 5'd5, 5'd5, 5'd5, 32'h1234_5678, 32'h0000_3000);
        step();
        drive(1'b0, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0);
        #1;
        chk("w5_rd1_byp", bus1.rd1, 32'h1234_5678);
        chk("w5_rd1_nob", bus0.rd1, 32'h1234_5678);
        chk("w5_dbg_we", {31'b0, bus1.dbg_we}, 32'h1);
        chk("w5_dbg_a3", {27'b0, bus1.dbg_a3}, 32'h5);
        chk("w5_dbg_wd", bus1.dbg_wd, 32'h1234_5678);

        // write to $0 is discarded
        drive(1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0000_3004);
        #1;
        chk("w0_rd1_same", bus1.rd1, 32'h0);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
        #1;
        chk("w0_rd1_next", bus1.rd1, 32'h0);
        chk("w0_dbg_we", {31'b0, bus1.dbg_we}, 32'h0);
        chk("w0_dbg_a3_hold", {27'b0, bus1.dbg_a3}, 32'h5);
        chk("w0_dbg_wd_hold", bus1.dbg_wd, 32'h1234_5678);

        // same-cycle bypass vs stored-only read
        drive(1'b1, 5'd8, 5'd8, 5'd8, 32'hA5A5_A5A5, 32'h0000_3008);
        #1;
        chk("byp_rd1", bus1.rd1, 32'hA5A5_A5A5);
        chk("byp_rd2", bus1.rd2, 32'hA5A5_A5A5);
        chk("nob_rd1", bus0.rd1, 32'h0);
        chk("nob_rd2", bus0.rd2, 32'h0);
        step();
        drive(1'b0, 5'd8, 5'd8, 5'd0, 32'h0, 32'h0);
        #1;
        chk("nob_rd1_after", bus0.rd1, 32'hA5A5_A5A5);

        // reset wins over a concurrent write
        drive(1'b1, 5'd31, 5'd31, 5'd31, 32'h0000_3008, 32'h0000_300C);
        step();
        reset = 1'b1;
        drive(1'b1, 5'd31, 5'd31, 5'd31, 32'h0000_0001, 32'h0000_3010);
        #1;
        chk("rst_byp_off", bus1.rd1, 32'h0000_3008);
        step();
        reset = 1'b0;
        drive(1'b0, 5'd31, 5'd8, 5'd0, 32'h0, 32'h0);
        #1;
        chk("rst31_rd1", bus1.rd1, 32'h0);
        chk("rst8_rd2", bus1.rd2, 32'h0);
        chk("rstw_dbg_we", {31'b0, bus1.dbg_we}, 32'h0);
        chk("rstw_dbg_a3", {27'b0, bus1.dbg_a3}, 32'h0);
        chk("rstw_dbg_wd", bus1.dbg_wd, 32'h0);

        // back-to-back writes to $9
        drive(1'b1, 5'd0, 5'd9, 5'd9, 32'h0000_0011, 32'h0000_3014);
        step();
        drive(1'b1, 5'd0, 5'd9, 5'd9, 32'h0000_0022, 32'h0000_3018);
        #1;
        chk("b2b_nob_mid", bus0.rd2, 32'h0000_0011);
        chk("b2b_byp_mid", bus1.rd2, 32'h0000_0022);
        step();
        drive(1'b0, 5'd0, 5'd9, 5'd0, 32'h0, 32'h0);
        #1;
        chk("b2b_rd2", bus1.rd2, 32'h0000_0022);
        chk("b2b_dbg_wd", bus1.dbg_wd, 32'h0000_0022);

        // sweep all registers
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'(i), 32'(i) * 32'h0101_0101, 32'h0000_4000 + 32'(i * 4));
            step();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0, 32'h0);
            #1;
            e1 = 32'(i) * 32'h0101_0101;
            e2 = 32'(31 - i) * 32'h0101_0101;
            chk($sformatf("sw_byp_rd1_%0d", i), bus1.rd1, e1);
            chk($sformatf("sw_byp_rd2_%0d", 31 - i), bus1.rd2, e2);
            chk($sformatf("sw_nob_rd1_%0d", i), bus0.rd1, e1);
            chk($sformatf("sw_nob_rd2_%0d", 31 - i), bus0.rd2, e2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/grf.md
# grf

General register file of the single-cycle MIPS datapath: the consumer of the register-write address mux and the write-data mux outputs. It holds 32 × 32-bit registers with `$0` hardwired to zero. It provides two combinational read ports for the decode/ALU side and one synchronous write port. Same-cycle write-to-read bypass lets the block drop unchanged into the pipelined datapath.

## Interface
Parameters:
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register index width; register count is 2^ADDR_W
- `BYPASS`, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads show stored value only

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- `we`  in  1  write enable
- `a1`  in  ADDR_W  read port 1 index (rs)
- `a2`  in  ADDR_W  read port 2 index (rt)
- `a3`  in  ADDR_W  write index, driven by the A3 mux (rd/rt/31)
- `wd`  in  DATA_W  write data, driven by the WD3 mux (ALU/mem/PC+4/other)
- `pc`  in  32  PC of the instruction writing; trace only
- `rd1`  out  DATA_W  read data 1
- `rd2`  out  DATA_W  read data 2
- `dbg_we`  out  1  registered: a write committed last edge
- `dbg_a3`  out  ADDR_W  registered index of last committed write
- `dbg_wd`  out  DATA_W  registered data of last committed write

## Operation
- Commit condition: `commit = we && !reset && (a3 != 0)`. On the rising edge with `commit`, `reg[a3] <= wd`.
- Writes with `a3 == 0` are discarded silently. They do not raise `dbg_we`.
- `reset` high at an edge does the following:
  - all registers clear to 0
  - `dbg_we`, `dbg_a3` and `dbg_wd` clear to 0
  - any concurrent write is dropped; reset wins
- Read port n (identical for both ports):
  - `an == 0` → 0, always
  - else if `BYPASS && commit && a3 == an` → `wd`
  - else → `reg[an]`
- Bypass is suppressed while `reset` is high. Reads then show stored contents.
- On every edge with `commit`, the debug registers capture: `dbg_we = 1`, `dbg_a3 = a3`, `dbg_wd = wd`. On an edge without `commit`, `dbg_we = 0` and `dbg_a3`/`dbg_wd` hold their values.
- Simulation trace (non-synthesizable, guarded): on each commit edge, print `@<pc hex 8>: $<a3 decimal 2> <= <wd hex 8>`. Writes to `$0` print nothing.

## Timing
- Read latency: combinational, 0 cycles.
- Write latency: the value is visible as stored on the cycle after the edge. With `BYPASS=1` it is also visible on read ports during the write cycle itself.
- Debug outputs lag the commit by exactly 1 edge.
- Reset values: every register = 0, `rd1`/`rd2` = 0 for any index, `dbg_*` = 0.
- Reset released mid-program: the first edge with `reset` low and `we` high commits normally.
- Simultaneous read of the same index on both ports: both return the same value, including bypassed data.
- Back-to-back writes to the same index: the last one wins and both are traced in order.

## Structure
- Shared package `grf_pkg`:
  - `REG_ZERO = 5'd0`
  - `REG_RA = 5'd31`
  - `NREG = 32`
  - `DATA_W`/`ADDR_W` default constants
- Sub-module `grf_read_port` implements the zero check, bypass compare and array select. It is instantiated twice, for `a1`/`rd1` and `a2`/`rd2`.
- Storage is a flat register array in `grf`. The debug registers and trace live in `grf`.

## Test plan
- Reset, then `we=1`, `a3=5`, `wd=0x1234_5678`, `pc=0x0000_3000` → next cycle `a1=5` reads `0x12345678`, `dbg_we=1`, `dbg_a3=5`, and the trace prints `@00003000: $ 5 <= 12345678`.
- `we=1`, `a3=0`, `wd=0xFFFF_FFFF` → `rd1` with `a1=0` stays 0 in the same and following cycles, `dbg_we=0`, and no trace line is printed.
- `BYPASS=1`: `we=1`, `a3=8`, `wd=0xA5A5_A5A5`, `a1=a2=8` in the same cycle → `rd1=rd2=0xA5A5A5A5` before the edge. With `BYPASS=0`, the same stimulus reads the old value 0.
- Write `reg31=0x0000_3008`, then assert `reset` for one edge together with `we=1`, `a3=31`, `wd=0x1` → `reg31` reads 0 after the edge and `dbg_we=0`.
- Write `a3=9` twice on consecutive edges with `0x11`, then `0x22` → `rd2` with `a2=9` = `0x22`, and two trace lines are printed in order.
- Sweep: write `reg[i]=i*0x0101_0101` for i = 1..31, then read every index on both ports → all values match and `reg0` = 0.
